bru_resolve_unit: RTL and testbench

- Producer end of the branch-update interface. Consumed by the next-PC/prediction logic as a branch_t package plus misprediction signalling.
- Records each predicted control-flow instruction at fetch in an in-order prediction queue.
- Resolves the real outcome when execute presents the operands, and compares it with the recorded prediction.
- Emits a registered predictor-update package and a flush pulse on misprediction. Sits between the execute stage and the next-PC unit.

---
 rtl/bru_resolve_unit_pkg.sv | 41 ++++
 rtl/bru_resolve_unit_if.sv | 39 +++
 rtl/bru_resolve_unit_pred_queue.sv | 72 +++++++
 rtl/bru_resolve_unit.sv | 139 +++++++++++++
 tb/tb_bru_resolve_unit.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bru_resolve_unit_pkg.sv
// Shared types for the branch resolve path: branch-update package, branch types, queue entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bru_resolve_unit_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd2,
    BR_BGE  = 3'd3,
    BR_BLTU = 3'd4,
    BR_BGEU = 3'd5,
    BR_JAL  = 3'd6,
    BR_JALR = 3'd7
  } br_type_t;

  // Predictor-update package consumed by the next-PC unit.
  typedef struct packed {
    logic        update_en;
    logic        valid;
    logic [31:0] pc_lookup;
    logic        taken;
    logic [31:0] target;
  } branch_t;

  // One recorded fetch-time prediction.
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } pred_entry_t;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } bru_state_t;

  // JALR targets always have bit 0 cleared.
  localparam logic [31:0] JALR_LSB_MASK = 32'hFFFF_FFFE;

endpackage

// File: rtl/bru_resolve_unit_if.sv
// Fetch-record, execute-resolve and predictor-update signals of the branch resolve unit.
// Latency: n/a (wiring only).
// Backpressure: o_prd_full stalls fetch; o_ex_ready gates execute resolves.
// Ports: master = fetch/execute/next-PC side, slave = bru_resolve_unit.
interface bru_resolve_unit_if #(
  parameter int DEPTH = 4
);
  import bru_resolve_unit_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             i_prd_push;
  logic [31:0]      i_prd_pc;
  logic             i_prd_taken;
  logic [31:0]      i_prd_target;
  logic             o_prd_full;
  logic             i_ex_valid;
  br_type_t         i_ex_br_type;
  logic [31:0]      i_ex_rs1;
  logic [31:0]      i_ex_rs2;
  logic [31:0]      i_ex_imm;
  logic             o_ex_ready;
  branch_t          o_bru_prd_pkg;
  logic             o_flush;
  logic [CNT_W-1:0] o_count;

  modport master (
    output i_prd_push, i_prd_pc, i_prd_taken, i_prd_target,
    output i_ex_valid, i_ex_br_type, i_ex_rs1, i_ex_rs2, i_ex_imm,
    input  o_prd_full, o_ex_ready, o_bru_prd_pkg, o_flush, o_count
  );

  modport slave (
    input  i_prd_push, i_prd_pc, i_prd_taken, i_prd_target,
    input  i_ex_valid, i_ex_br_type, i_ex_rs1, i_ex_rs2, i_ex_imm,
    output o_prd_full, o_ex_ready, o_bru_prd_pkg, o_flush, o_count
  );

endinterface

// File: rtl/bru_resolve_unit_pred_queue.sv
// In-order circular prediction queue with synchronous clear.
// Latency: head data is combinational from storage; a push is visible at head the cycle after.
// Backpressure: push dropped when full unless a pop happens the same cycle; clear wins over push/pop.
// Ports: clk_i, rst_ni (sync active-low), push_i/data_i, pop_i, clear_i, data_o (head), full_o, empty_o, count_o.
module pred_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic [W-1:0]               data_i,
  output logic [W-1:0]               data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read when count says they are live.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bru_resolve_unit.sv
// Branch resolve unit: records fetch predictions, resolves them at execute, emits predictor update + flush.
// Latency: update package and flush are registered, one cycle after the resolve.
// Backpressure: o_prd_full stalls fetch; o_ex_ready low when queue empty or during post-flush recovery.
// Ports: i_clk, i_rst_n (sync active-low), bus (slave modport of bru_resolve_unit_if).
module bru_resolve_unit
  import bru_resolve_unit_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int RECOVER_CYC = 2
) (
  input logic               i_clk,
  input logic               i_rst_n,
  bru_resolve_unit_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYC);

  bru_state_t  state_q, state_d;
  logic [3:0]  rcv_cnt_q, rcv_cnt_d;
  branch_t     pkg_q;
  logic        flush_q;

  pred_entry_t                    push_entry, head;
  logic [$bits(pred_entry_t)-1:0] head_raw;
  logic                           q_empty, q_full;
  logic [CNT_W-1:0]               q_count;

  logic        run, resolve, mispredict, act_taken;
  logic [31:0] act_tgt, jalr_sum;

  assign run            = (state_q == ST_RUN);
  assign bus.o_ex_ready = run & ~q_empty;
  assign resolve        = bus.i_ex_valid & bus.o_ex_ready;
  assign push_entry     = {bus.i_prd_pc, bus.i_prd_taken, bus.i_prd_target};
  assign head           = pred_entry_t'(head_raw);

  // A mispredict clears the queue at the same edge, which also discards any same-cycle push.
  pred_queue #(
    .DEPTH (DEPTH),
    .W     ($bits(pred_entry_t))
  ) u_pred_queue (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (bus.i_prd_push & run),
    .pop_i   (resolve),
    .clear_i (resolve & mispredict),
    .data_i  (push_entry),
    .data_o  (head_raw),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  assign bus.o_prd_full = q_full;
  assign bus.o_count    = q_count;

  // Real outcome of the head instruction.
  assign jalr_sum = bus.i_ex_rs1 + bus.i_ex_imm;

  always_comb begin
    act_taken = 1'b0;
    case (bus.i_ex_br_type)
      BR_BEQ:  act_taken = (bus.i_ex_rs1 == bus.i_ex_rs2);
      BR_BNE:  act_taken = (bus.i_ex_rs1 != bus.i_ex_rs2);
      BR_BLT:  act_taken = ($signed(bus.i_ex_rs1) <  $signed(bus.i_ex_rs2));
      BR_BGE:  act_taken = ($signed(bus.i_ex_rs1) >= $signed(bus.i_ex_rs2));
      BR_BLTU: act_taken = (bus.i_ex_rs1 <  bus.i_ex_rs2);
      BR_BGEU: act_taken = (bus.i_ex_rs1 >= bus.i_ex_rs2);
      BR_JAL:  act_taken = 1'b1;
      BR_JALR: act_taken = 1'b1;
      default: act_taken = 1'b0;
    endcase
  end

  assign act_tgt = (bus.i_ex_br_type == BR_JALR) ? (jalr_sum & JALR_LSB_MASK)
                                                 : (head.pc + bus.i_ex_imm);

  // Target only matters when both actual and predicted are taken.
  assign mispredict = (act_taken != head.taken) |
                      (act_taken & head.taken & (act_tgt != head.target));

  // FSM: next-state / counter.
  always_comb begin
    state_d   = state_q;
    rcv_cnt_d = rcv_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (resolve && mispredict) begin
          state_d   = ST_RECOVER;
          rcv_cnt_d = RECOVER_LOAD;
        end
      end
      ST_RECOVER: begin
        rcv_cnt_d = rcv_cnt_q - 4'd1;
        if (rcv_cnt_q <= 4'd1) begin
          state_d   = ST_RUN;
          rcv_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d   = ST_RUN;
        rcv_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_RUN;
      rcv_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      rcv_cnt_q <= rcv_cnt_d;
    end
  end

  // Update package: strobes pulse for one cycle; pc/taken/target hold between resolves.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pkg_q   <= '0;
      flush_q <= 1'b0;
    end else if (resolve) begin
      pkg_q.update_en <= 1'b1;
      pkg_q.valid     <= 1'b1;
      pkg_q.pc_lookup <= head.pc;
      pkg_q.taken     <= act_taken;
      pkg_q.target    <= act_tgt;
      flush_q         <= mispredict;
    end else begin
      pkg_q.update_en <= 1'b0;
      pkg_q.valid     <= 1'b0;
      flush_q         <= 1'b0;
    end
  end

  assign bus.o_bru_prd_pkg = pkg_q;
  assign bus.o_flush       = flush_q;

endmodule

// File: tb/tb_bru_resolve_unit.sv
module tb_bru_resolve_unit;
  import bru_resolve_unit_pkg::*;

  localparam int DEPTH = 4;
  localparam int RCV   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bru_resolve_unit_if #(.DEPTH(DEPTH)) bif ();

  bru_resolve_unit #(.DEPTH(DEPTH), .RECOVER_CYC(RCV)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bif.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: list of outstanding predictions, cycles of recovery left, expected outputs.
  typedef struct {
    logic [31:0] pc;
    bit          tk;
    logic [31:0] tgt;
  } ent_t;

  ent_t    mq[$];
  int      m_rec = 0;
  branch_t e_pkg = '0;
  bit      e_flush = 1'b0;

  function automatic void ref_outcome(input int t, input logic [31:0] rs1, input logic [31:0] rs2,
                                      input logic [31:0] imm, input logic [31:0] pc,
                                      output bit tk, output logic [31:0] tgt);
    logic [31:0] s;
    case (t)
      0: tk = (rs1 == rs2);
      1: tk = (rs1 != rs2);
      2: tk = ($signed(rs1) < $signed(rs2));
      3: tk = !($signed(rs1) < $signed(rs2));
      4: tk = (rs1 < rs2);
      5: tk = !(rs1 < rs2);
      default: tk = 1'b1;
    endcase
    s = rs1 + imm;
    if (t == 7) tgt = {s[31:1], 1'b0};
    else        tgt = pc + imm;
  endfunction

  task automatic drive(input bit push, input logic [31:0] pc, input bit ptk, input logic [31:0] ptgt,
                       input bit exv, input int bt, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm);
    bif.i_prd_push   = push;
    bif.i_prd_pc     = pc;
    bif.i_prd_taken  = ptk;
    bif.i_prd_target = ptgt;
    bif.i_ex_valid   = exv;
    bif.i_ex_br_type = br_type_t'(3'(bt));
    bif.i_ex_rs1     = rs1;
    bif.i_ex_rs2     = rs2;
    bif.i_ex_imm     = imm;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance the model with the inputs currently driven, then clock the DUT and sample after the edge.
  task automatic step();
    bit          ready, resolve, tk, mis;
    logic [31:0] tgt;
    ent_t        h, n;
    if (!rst_n) begin
      mq.delete();
      m_rec   = 0;
      e_pkg   = '0;
      e_flush = 1'b0;
    end else begin
      ready   = (m_rec == 0) && (mq.size() != 0);
      resolve = bif.i_ex_valid && ready;
      mis     = 1'b0;
      if (resolve) begin
        h = mq.pop_front();
        ref_outcome(int'(bif.i_ex_br_type), bif.i_ex_rs1, bif.i_ex_rs2, bif.i_ex_imm, h.pc, tk, tgt);
        mis = (tk != h.tk) || (tk && h.tk && tgt != h.tgt);
        e_pkg.update_en = 1'b1;
        e_pkg.valid     = 1'b1;
        e_pkg.pc_lookup = h.pc;
        e_pkg.taken     = tk;
        e_pkg.target    = tgt;
        e_flush         = mis;
      end else begin
        e_pkg.update_en = 1'b0;
        e_pkg.valid     = 1'b0;
        e_flush         = 1'b0;
      end
      if (m_rec == 0 && bif.i_prd_push && !mis && mq.size() < DEPTH) begin
        n.pc = bif.i_prd_pc; n.tk = bif.i_prd_taken; n.tgt = bif.i_prd_target;
        mq.push_back(n);
      end
      if (mis) begin
        mq.delete();
        m_rec = RCV;
      end else if (m_rec > 0) begin
        m_rec--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    step();
    step();
    rst_n = 1'b1;
    step();
    n_chk++; if (bif.o_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bif.o_count); end
    n_chk++; if (bif.o_ex_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", bif.o_ex_ready); end
    n_chk++; if (bif.o_prd_full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", bif.o_prd_full); end
    n_chk++; if (bif.o_bru_prd_pkg !== branch_t'(0)) begin n_err++; $display("FAIL reset_pkg got %h want 0", bif.o_bru_prd_pkg); end
    n_chk++; if (bif.o_flush !== 1'b0) begin n_err++; $display("FAIL reset_flush got %b want 0", bif.o_flush); end
  endtask

  task automatic test_correct_pred();
    branch_t x;
    drive(1, 32'h100, 0, 32'h0, 0, 0, 0, 0, 0);
    step();
    n_chk++; if (bif.o_ex_ready !== 1'b1) begin n_err++; $display("FAIL corr_ready got %b want 1", bif.o_ex_ready); end
    drive(0, 0, 0, 0, 1, 0, 32'd1, 32'd2, 32'h40);
    step();
    x.update_en = 1'b1; x.valid = 1'b1; x.pc_lookup = 32'h100; x.taken = 1'b0; x.target = 32'h140;
    n_chk++; if (bif.o_bru_prd_pkg !== x) begin n_err++; $display("FAIL corr_pkg got %h want %h", bif.o_bru_prd_pkg, x); end
    n_chk++; if (bif.o_flush !== 1'b0) begin n_err++; $display("FAIL corr_flush got %b want 0", bif.o_flush); end
    idle();
    step();
    n_chk++; if (bif.o_bru_prd_pkg.valid !== 1'b0 || bif.o_bru_prd_pkg.target !== 32'h140)
      begin n_err++; $display("FAIL corr_hold got %h want valid=0 target=140", bif.o_bru_prd_pkg); end
  endtask

  task automatic test_taken_miss();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h200 + 32'(4 * i), 0, 32'h0, 0, 0, 0, 0, 0);
      step();
    end
    n_chk++; if (bif.o_count !== 3'd3) begin n_err++; $display("FAIL miss_fill got %0d want 3", bif.o_count); end
    drive(0, 0, 0, 0, 1, 2, 32'hFFFF_FFFF, 32'h0, 32'h10);
    step();
    n_chk++; if (bif.o_bru_prd_pkg.taken !== 1'b1 || bif.o_bru_prd_pkg.target !== 32'h210 ||
                 bif.o_bru_prd_pkg.pc_lookup !== 32'h200)
      begin n_err++; $display("FAIL miss_pkg got %h want taken=1 tgt=210 pc=200", bif.o_bru_prd_pkg); end
    n_chk++; if (bif.o_flush !== 1'b1) begin n_err++; $display("FAIL miss_flush got %b want 1", bif.o_flush); end
    n_chk++; if (bif.o_count !== 3'd0) begin n_err++; $display("FAIL miss_clear got %0d want 0", bif.o_count); end
    for (int i = 0; i < RCV; i++) begin
      drive(1, 32'h280, 0, 32'h0, 1, 1, 5, 5, 0);
      step();
      n_chk++; if (bif.o_count !== 3'd0) begin n_err++; $display("FAIL miss_ignore%0d got %0d want 0", i, bif.o_count); end
      n_chk++; if (bif.o_flush !== 1'b0) begin n_err++; $display("FAIL miss_flush_pulse%0d got %b want 0", i, bif.o_flush); end
    end
    drive(1, 32'h280, 0, 32'h0, 0, 0, 0, 0, 0);
    step();
    n_chk++; if (bif.o_count !== 3'd1) begin n_err++; $display("FAIL miss_resume got %0d want 1", bif.o_count); end
    drive(0, 0, 0, 0, 1, 1, 5, 5, 0);
    step();
    n_chk++; if (bif.o_flush !== 1'b0 || bif.o_bru_prd_pkg.pc_lookup !== 32'h280)
      begin n_err++; $display("FAIL miss_drain got flush=%b pc=%h want 0/280", bif.o_flush, bif.o_bru_prd_pkg.pc_lookup); end
    idle();
    step();
  endtask

  task automatic test_jalr_miss();
    drive(1, 32'h300, 1, 32'h400, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 7, 32'h501, 32'h0, 32'h0);
    step();
    n_chk++; if (bif.o_bru_prd_pkg.target !== 32'h500 || bif.o_bru_prd_pkg.taken !== 1'b1)
      begin n_err++; $display("FAIL jalr_pkg got %h want taken=1 tgt=500", bif.o_bru_prd_pkg); end
    n_chk++; if (bif.o_flush !== 1'b1) begin n_err++; $display("FAIL jalr_flush got %b want 1", bif.o_flush); end
    idle();
    for (int i = 0; i < RCV + 1; i++) step();
  endtask

  task automatic test_full();
    logic [31:0] want[$];
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'h1000 + 32'(4 * i), 0, 32'h0, 0, 0, 0, 0, 0);
      step();
    end
    n_chk++; if (bif.o_prd_full !== 1'b1) begin n_err++; $display("FAIL full_flag got %b want 1", bif.o_prd_full); end
    drive(1, 32'h2000, 0, 32'h0, 0, 0, 0, 0, 0);
    step();
    n_chk++; if (bif.o_count !== 3'd4) begin n_err++; $display("FAIL full_drop got %0d want 4", bif.o_count); end
    drive(1, 32'h3000, 0, 32'h0, 1, 0, 32'd1, 32'd2, 32'h8);
    step();
    n_chk++; if (bif.o_count !== 3'd4 || bif.o_bru_prd_pkg.pc_lookup !== 32'h1000)
      begin n_err++; $display("FAIL full_pushpop got cnt=%0d pc=%h want 4/1000", bif.o_count, bif.o_bru_prd_pkg.pc_lookup); end
    want = '{32'h1004, 32'h1008, 32'h100C, 32'h3000};
    foreach (want[i]) begin
      drive(0, 0, 0, 0, 1, 0, 32'd1, 32'd2, 32'h8);
      step();
      n_chk++; if (bif.o_bru_prd_pkg.pc_lookup !== want[i])
        begin n_err++; $display("FAIL full_order%0d got %h want %h", i, bif.o_bru_prd_pkg.pc_lookup, want[i]); end
    end
    drive(1, 32'h5000, 0, 32'h0, 0, 0, 0, 0, 0);
    step();
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h5000 + 32'(4 * (k + 1)), 0, 32'h0, 1, 4, 32'd9, 32'd3, 32'h4);
      step();
      n_chk++; if (bif.o_bru_prd_pkg.pc_lookup !== 32'h5000 + 32'(4 * k) || bif.o_count !== 3'd1)
        begin n_err++; $display("FAIL wrap%0d got pc=%h cnt=%0d want %h/1", k, bif.o_bru_prd_pkg.pc_lookup,
                                bif.o_count, 32'h5000 + 32'(4 * k)); end
    end
    drive(0, 0, 0, 0, 1, 4, 32'd9, 32'd3, 32'h4);
    step();
    idle();
    step();
  endtask

  task automatic test_random();
    logic [31:0] ops[5];
    logic [31:0] pc;
    bit          rdy;
    for (int c = 0; c < 400; c++) begin
      ops = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, $urandom()};
      pc  = {$urandom_range(0, 255), 2'b00};
      drive($urandom_range(0, 1), pc, $urandom_range(0, 1), pc + 32'h40,
            $urandom_range(0, 9) < 6, $urandom_range(0, 7),
            ops[$urandom_range(0, 4)], ops[$urandom_range(0, 4)],
            ($urandom_range(0, 1) != 0) ? 32'h40 : {$urandom_range(0, 63), 1'b0});
      step();
      rdy = (m_rec == 0) && (mq.size() != 0);
      n_chk++; if (bif.o_count !== 3'(mq.size())) begin n_err++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, bif.o_count, mq.size()); end
      n_chk++; if (bif.o_ex_ready !== rdy) begin n_err++; $display("FAIL rnd_ready c=%0d got %b want %b", c, bif.o_ex_ready, rdy); end
      n_chk++; if (bif.o_prd_full !== (mq.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full c=%0d got %b", c, bif.o_prd_full); end
      n_chk++; if (bif.o_bru_prd_pkg !== e_pkg) begin n_err++; $display("FAIL rnd_pkg c=%0d got %h want %h", c, bif.o_bru_prd_pkg, e_pkg); end
      n_chk++; if (bif.o_flush !== e_flush) begin n_err++; $display("FAIL rnd_flush c=%0d got %b want %b", c, bif.o_flush, e_flush); end
    end
    idle();
    for (int i = 0; i < RCV + 1; i++) step();
    while (mq.size() != 0 && n_err < 1000) begin
      drive(0, 0, 0, 0, 1, 6, 0, 0, 0);
      step();
      idle();
      for (int i = 0; i < RCV + 1; i++) step();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h700 + 32'(4 * i), 0, 32'h0, 0, 0, 0, 0, 0);
      step();
    end
    rst_n = 1'b0;
    idle();
    step();
    rst_n = 1'b1;
    n_chk++; if (bif.o_count !== 3'd0) begin n_err++; $display("FAIL rstmid_count got %0d want 0", bif.o_count); end
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h800 + 32'(4 * i), 0, 32'h0, 0, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 1, 0, 32'd7, 32'd7, 32'h4);
    step();
    n_chk++; if (bif.o_flush !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got %b want 1", bif.o_flush); end
    rst_n = 1'b0;
    idle();
    step();
    rst_n = 1'b1;
    n_chk++; if (bif.o_flush !== 1'b0 || bif.o_bru_prd_pkg !== branch_t'(0))
      begin n_err++; $display("FAIL rstmid_out got flush=%b pkg=%h want 0/0", bif.o_flush, bif.o_bru_prd_pkg); end
    drive(1, 32'h900, 0, 32'h0, 0, 0, 0, 0, 0);
    step();
    n_chk++; if (bif.o_count !== 3'd1 || bif.o_ex_ready !== 1'b1)
      begin n_err++; $display("FAIL rstmid_run got cnt=%0d rdy=%b want 1/1", bif.o_count, bif.o_ex_ready); end
    idle();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_correct_pred();
    test_taken_miss();
    test_jalr_miss();
    test_full();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
